// File: rtl/pipe_adder_pkg.sv
// Shared definitions for the pipelined add/subtract unit.
package pipe_adder_pkg;

    // Operation select on sub_in.
    localparam logic ADD = 1'b0;
    localparam logic SUB = 1'b1;

    localparam int MAX_STAGES = 8;

    // Legal geometry: 1..MAX_STAGES stages, each resolving a whole number of bits.
    function automatic bit params_ok(input int width, input int stages);
        return (stages >= 1) && (stages <= MAX_STAGES) &&
               (width >= stages) && ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/pipe_add_stage.sv
// One CHUNK-bit slice of the pipelined adder. It holds the operand skew, the
// partially assembled result, the carry into the next slice and a valid bit.
module pipe_add_stage
    import pipe_adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 16,
    parameter int IDX   = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic [WIDTH-1:0] res_in,
    input  logic             carry_in,
    input  logic             advance,
    output logic             ready,
    output logic             load,
    output logic             valid_out,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] b_out,
    output logic [WIDTH-1:0] res_out,
    output logic             carry_out,
    output logic [WIDTH-1:0] res_next
);

    localparam int LSB = IDX * CHUNK;

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             carry_q, carry_d;
    logic [CHUNK:0]   chunk_sum;

    // Add this slice's chunk and splice it into the partial result.
    always_comb begin
        chunk_sum = {1'b0, a_in[LSB +: CHUNK]} + {1'b0, b_in[LSB +: CHUNK]} +
                    {{CHUNK{1'b0}}, carry_in};
        res_next = res_in;
        res_next[LSB +: CHUNK] = chunk_sum[CHUNK-1:0];
    end

    // Accept when empty or when the current contents move on in this cycle.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        ready   = !valid_q || advance;
        load    = valid_in && ready;
        valid_d = valid_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        carry_d = carry_q;
        if (load) begin
            valid_d = 1'b1;
            a_d     = a_in;
            b_d     = b_in;
            res_d   = res_next;
            carry_d = chunk_sum[CHUNK];
        end else if (advance) begin
            valid_d = 1'b0;
        end
    end

    // Slice registers; data is cleared on reset too so nothing stale can surface.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            valid_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            carry_q <= carry_d;
        end
    end

    assign valid_out = valid_q;
    assign a_out     = a_q;
    assign b_out     = b_q;
    assign res_out   = res_q;
    assign carry_out = carry_q;

endmodule

// File: rtl/pipe_adder.sv
// Pipelined WIDTH-bit add/subtract with valid/ready handshake. STAGES slices
// each resolve CHUNK bits; the top owns the operand conditioning, the ready
// chain and the registered overflow/zero flags.
module pipe_adder
    import pipe_adder_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             sub_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result_out,
    output logic             carry_out,
    output logic             overflow_out,
    output logic             zero_out
);

    localparam int CHUNK = WIDTH / STAGES;
    localparam int MSB   = WIDTH - 1;
    localparam int LAST  = STAGES - 1;

    if (!params_ok(WIDTH, STAGES)) begin : g_param_check
        $error("pipe_adder: STAGES must be 1..8 and divide WIDTH");
    end

    // Element k feeds slice k; element STAGES is the last slice's registered state.
    logic             v_s [STAGES+1];
    logic [WIDTH-1:0] a_s [STAGES+1];
    logic [WIDTH-1:0] b_s [STAGES+1];
    logic [WIDTH-1:0] r_s [STAGES+1];
    logic             c_s [STAGES+1];
    logic [WIDTH-1:0] res_next [STAGES];
    logic             load_s [STAGES];

    logic ovf_q, ovf_d;
    logic zero_q, zero_d;

    // Subtract is A + ~B + 1: invert B up front and use the carry-in as the +1.
    assign v_s[0] = in_valid;
    assign a_s[0] = a_in;
    assign b_s[0] = (sub_in == SUB) ? ~b_in : b_in;
    assign r_s[0] = '0;
    assign c_s[0] = (sub_in == SUB);

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic ready;
        logic advance;

        if (k == LAST) begin : g_tail
            assign advance = out_ready;
        end else begin : g_mid
            assign advance = g_stage[k+1].ready;
        end

        pipe_add_stage #(
            .WIDTH(WIDTH),
            .CHUNK(CHUNK),
            .IDX  (k)
        ) u_stage (
            .clk      (clk),
            .rst_n    (rst_n),
            .valid_in (v_s[k]),
            .a_in     (a_s[k]),
            .b_in     (b_s[k]),
            .res_in   (r_s[k]),
            .carry_in (c_s[k]),
            .advance  (advance),
            .ready    (ready),
            .load     (load_s[k]),
            .valid_out(v_s[k+1]),
            .a_out    (a_s[k+1]),
            .b_out    (b_s[k+1]),
            .res_out  (r_s[k+1]),
            .carry_out(c_s[k+1]),
            .res_next (res_next[k])
        );
    end

    // Flags come from the last slice's inputs and are captured with its result.
    always_comb begin
        ovf_d  = ovf_q;
        zero_d = zero_q;
        if (load_s[LAST]) begin
            ovf_d  = (a_s[LAST][MSB] == b_s[LAST][MSB]) &&
                     (res_next[LAST][MSB] != a_s[LAST][MSB]);
            zero_d = (res_next[LAST] == '0);
        end
    end

    // Flag registers share the last slice's hold/load behaviour.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else begin
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
        end
    end

    assign in_ready     = g_stage[0].ready;
    assign out_valid    = v_s[STAGES];
    assign result_out   = r_s[STAGES];
    assign carry_out    = c_s[STAGES];
    assign overflow_out = ovf_q;
    assign zero_out     = zero_q;

endmodule
